// File: rtl/data_memory_mc.sv
// rtl/data_memory_mc.sv - multi-cycle big-endian byte-addressable data memory
//
// Purpose : request/response data memory built from four byte lanes.
//           An access that fits in one row takes one ACC cycle. An access that
//           crosses a row boundary takes two ACC cycles: ACC0 for the first row,
//           then ACC1 for the next row. Illegal requests skip straight to RESP.
// Ports   : clk, rst_n (async, active-low)
//           req_valid / req_ready  request handshake
//           write_enable, addr, write_data, loadStoreMode  request fields
//           resp_valid  one-cycle response strobe
//           read_data, resp_err  response fields, held until the next response
module data_memory_mc #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    input  logic [2:0]        loadStoreMode,
    output logic              resp_valid,
    output logic [31:0]       read_data,
    output logic              resp_err
);
    localparam int ROWS  = DEPTH_BYTES / 4;
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t            r_state, w_next;
    logic              r_alive;
    logic              r_we;
    logic [1:0]        r_off;
    logic [ROW_W-1:0]  r_row;
    logic [1:0]        r_size;
    logic              r_zext;
    logic [31:0]       r_wdata;
    logic [7:0]        r_bytes [4];
    logic [31:0]       r_read_data;
    logic              r_err;

    logic              w_accept;
    logic [2:0]        w_in_nb;
    logic [ADDR_W:0]   w_end;
    logic              w_illegal;
    logic [2:0]        w_nb;
    logic [2:0]        w_span;
    logic              w_cross;
    logic [ROW_W-1:0]  w_row_acc;
    logic [3:0]        w_touch;
    logic [1:0]        w_k     [4];
    logic [7:0]        w_rbyte [4];
    logic [7:0]        w_wbyte [4];
    logic [7:0]        w_gath  [4];
    logic [31:0]       w_load_val;

    // r_alive keeps req_ready low while reset is held and until the first edge after release.
    assign req_ready  = (r_state == IDLE) && r_alive;
    assign resp_valid = (r_state == RESP);
    assign read_data  = r_read_data;
    assign resp_err   = r_err;
    assign w_accept   = req_valid && req_ready;

    // Legality is decided on the live inputs at accept. The extra top bit stops an
    // access near the top of the address space from wrapping into range.
    always_comb begin
        case (loadStoreMode[1:0])
            2'b00:   w_in_nb = 3'd1;
            2'b01:   w_in_nb = 3'd2;
            default: w_in_nb = 3'd4;
        endcase
        w_end     = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, w_in_nb} - {{ADDR_W{1'b0}}, 1'b1};
        w_illegal = (loadStoreMode[1:0] == 2'b11) || (w_end >= DEPTH_L);
    end

    always_comb begin
        case (r_size)
            2'b00:   w_nb = 3'd1;
            2'b01:   w_nb = 3'd2;
            default: w_nb = 3'd4;
        endcase
        w_span    = {1'b0, r_off} + w_nb;
        w_cross   = (w_span > 3'd4);
        w_row_acc = (r_state == ACC1) ? r_row + ROW_W'(1) : r_row;
    end

    // For each lane: is it touched this cycle, and which byte of the access (0 = MSB) it carries.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            w_touch[l]   = 1'b0;
            w_k[l]       = 2'd0;
            w_wbyte[l]   = 8'd0;
            if (r_state == ACC0 && 3'(l) >= {1'b0, r_off} && 3'(l) < w_span) begin
                w_touch[l] = 1'b1;
                w_k[l]     = 2'(3'(l) - {1'b0, r_off});
            end else if (r_state == ACC1 && (3'(l) + 3'd4) < w_span) begin
                w_touch[l] = 1'b1;
                w_k[l]     = 2'(3'(l) + 3'd4 - {1'b0, r_off});
            end
            w_wbyte[l] = r_wdata[{2'(w_nb - 3'd1 - {1'b0, w_k[l]}), 3'b000} +: 8];
        end
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] r_mem [ROWS];

        // Contents survive reset. An asynchronous reset forces IDLE, so a pending
        // ACC1 never commits its bytes.
        always_ff @(posedge clk) begin
            if (r_we && w_touch[l]) begin
                r_mem[w_row_acc] <= w_wbyte[l];
            end
        end

        assign w_rbyte[l] = r_mem[w_row_acc];
    end

    // Bytes gathered so far plus the lanes read this cycle, in access order.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_gath[k] = r_bytes[k];
        end
        for (int l = 0; l < 4; l++) begin
            if (w_touch[l]) begin
                w_gath[w_k[l]] = w_rbyte[l];
            end
        end
    end

    always_comb begin
        w_load_val = {w_gath[0], w_gath[1], w_gath[2], w_gath[3]};
        case (r_size)
            2'b00: w_load_val = r_zext ? {24'd0, w_gath[0]}
                                       : {{24{w_gath[0][7]}}, w_gath[0]};
            2'b01: w_load_val = r_zext ? {16'd0, w_gath[0], w_gath[1]}
                                       : {{16{w_gath[0][7]}}, w_gath[0], w_gath[1]};
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_illegal ? RESP : ACC0;
            ACC0: w_next = w_cross ? ACC1 : RESP;
            ACC1: w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_alive     <= 1'b0;
            r_we        <= 1'b0;
            r_off       <= 2'd0;
            r_row       <= '0;
            r_size      <= 2'd0;
            r_zext      <= 1'b0;
            r_wdata     <= 32'd0;
            r_read_data <= 32'd0;
            r_err       <= 1'b0;
            for (int k = 0; k < 4; k++) r_bytes[k] <= 8'd0;
        end else begin
            r_state <= w_next;
            r_alive <= 1'b1;
            if (w_accept) begin
                r_we    <= write_enable;
                r_off   <= addr[1:0];
                r_row   <= addr[ROW_W+1:2];
                r_size  <= loadStoreMode[1:0];
                r_zext  <= loadStoreMode[2];
                r_wdata <= write_data;
                for (int k = 0; k < 4; k++) r_bytes[k] <= 8'd0;
                if (w_illegal) begin
                    r_read_data <= 32'd0;
                    r_err       <= 1'b1;
                end
            end
            if (r_state == ACC0 || r_state == ACC1) begin
                for (int k = 0; k < 4; k++) r_bytes[k] <= w_gath[k];
                if (w_next == RESP) begin
                    r_err       <= 1'b0;
                    r_read_data <= r_we ? 32'd0 : w_load_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_mc.sv
// tb/tb_data_memory_mc.sv - scoreboard bench for data_memory_mc
module tb_data_memory_mc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        write_enable;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [2:0]  loadStoreMode;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        resp_err;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    data_memory_mc #(.DEPTH_BYTES(1024), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .write_enable(write_enable), .addr(addr), .write_data(write_data),
        .loadStoreMode(loadStoreMode),
        .resp_valid(resp_valid), .read_data(read_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, read_data, e.rd);
            chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
            if (lat >= 0) chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] m,
                          input logic [31:0] erd, input logic eerr, input int elat);
        exp_t e;
        int   n;
        int   lat;
        logic got;
        logic [31:0] held;
        e.rd = erd; e.err = eerr; e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; write_enable = we; addr = a; write_data = wd; loadStoreMode = m;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        write_enable = 1'($urandom); addr = $urandom; write_data = $urandom;
        loadStoreMode = 3'($urandom);
        lat = 0; got = 1'b0;
        while (lat < 10 && !got) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1'b1;
        end
        if (!got) begin
            chk({tag, "_resp_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            pop_cmp(tag, lat);
            held = read_data;
            @(negedge clk);
            chk({tag, "_strobe_one_cycle"}, {31'd0, resp_valid}, 32'd0);
            chk({tag, "_hold"}, read_data, held);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int rsp;
        exp_t e;
        rst_n = 1'b0; req_valid = 1'b0; write_enable = 1'b0;
        addr = 32'd0; write_data = 32'd0; loadStoreMode = 3'd0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_data", read_data, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_edge", {31'd0, req_ready}, 32'd1);

        do_req("sw10",   1, 32'h10, 32'h11223344, 3'b010, 32'h0, 0, 2);
        do_req("lw10",   0, 32'h10, 32'h0,        3'b010, 32'h11223344, 0, 2);
        do_req("lb10",   0, 32'h10, 32'h0,        3'b000, 32'h00000011, 0, 2);
        do_req("sh20",   1, 32'h20, 32'h80FF,     3'b001, 32'h0, 0, 2);
        do_req("lh20",   0, 32'h20, 32'h0,        3'b001, 32'hFFFF80FF, 0, 2);
        do_req("lhu20",  0, 32'h20, 32'h0,        3'b101, 32'h000080FF, 0, 2);
        do_req("sw0e",   1, 32'h0E, 32'hAABBCCDD, 3'b010, 32'h0, 0, 3);
        do_req("lw0e",   0, 32'h0E, 32'h0,        3'b010, 32'hAABBCCDD, 0, 3);
        do_req("lb10b",  0, 32'h10, 32'h0,        3'b000, 32'hFFFFFFCC, 0, 2);
        do_req("lw_oob", 0, 32'd1022, 32'h0,      3'b010, 32'h0, 1, 1);
        do_req("st_m11", 1, 32'h10, 32'hDEADBEEF, 3'b011, 32'h0, 1, 1);
        do_req("lw10c",  0, 32'h10, 32'h0,        3'b010, 32'hCCDD3344, 0, 2);
        do_req("lw_wrap",0, 32'hFFFFFFFE, 32'h0,  3'b010, 32'h0, 1, 1);
        do_req("sw_top", 1, 32'd1020, 32'h5A6B7C8D, 3'b010, 32'h0, 0, 2);
        do_req("lw_top", 0, 32'd1020, 32'h0,      3'b010, 32'h5A6B7C8D, 0, 2);
        do_req("lh_oob", 0, 32'd1023, 32'h0,      3'b001, 32'h0, 1, 1);
        do_req("lbu_top",0, 32'd1023, 32'h0,      3'b100, 32'h0000008D, 0, 2);
        do_req("lb_top", 0, 32'd1023, 32'h0,      3'b000, 32'hFFFFFF8D, 0, 2);
        do_req("sb21",   1, 32'h21, 32'h00000117, 3'b000, 32'h0, 0, 2);
        do_req("lhu20b", 0, 32'h20, 32'h0,        3'b101, 32'h00008017, 0, 2);
        do_req("lhu0f",  0, 32'h0F, 32'h0,        3'b101, 32'h0000BBCC, 0, 3);

        // Back-to-back: valid held high; one accept per response, every third cycle.
        acc = 0; rsp = 0;
        @(negedge clk);
        req_valid = 1'b1; write_enable = 1'b0; addr = 32'h10; loadStoreMode = 3'b010;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 14) req_valid = 1'b0;
            if (resp_valid) begin
                rsp++;
                pop_cmp("b2b", -1);
            end
            if (req_valid && req_ready) begin
                acc++;
                e.rd = 32'hCCDD3344; e.err = 1'b0; e.lat = 2;
                sb.push_back(e);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                rsp++;
                pop_cmp("b2b_tail", -1);
            end
        end
        chk("b2b_accepts", 32'(acc), 32'd5);
        chk("b2b_responses", 32'(rsp), 32'(acc));

        // Reset in ACC1 of a crossing store: first-row bytes stay, second-row bytes dropped.
        do_req("sw04z", 1, 32'h04, 32'h0, 3'b010, 32'h0, 0, 2);
        do_req("sw08z", 1, 32'h08, 32'h0, 3'b010, 32'h0, 0, 2);
        @(negedge clk);
        req_valid = 1'b1; write_enable = 1'b1; addr = 32'h06;
        write_data = 32'h01020304; loadStoreMode = 3'b010;
        chk("xrst_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("xrst_acc0_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("xrst_ready0", {31'd0, req_ready}, 32'd0);
        chk("xrst_valid0", {31'd0, resp_valid}, 32'd0);
        chk("xrst_data0", read_data, 32'd0);
        chk("xrst_err0", {31'd0, resp_err}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("xrst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("xrst_no_resp_after", {31'd0, resp_valid}, 32'd0);
        end
        do_req("lhu06", 0, 32'h06, 32'h0, 3'b101, 32'h00000102, 0, 2);
        do_req("lhu08", 0, 32'h08, 32'h0, 3'b101, 32'h00000000, 0, 2);
        do_req("lw04",  0, 32'h04, 32'h0, 3'b010, 32'h00000102, 0, 2);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
